// File: rtl/keypad_lock_if.sv
// keypad_lock_if: keypad buttons, expected code and indicator outputs of keypad_lock
interface keypad_lock_if #(
    parameter int N_KEYS   = 4,
    parameter int CODE_LEN = 4
);
    localparam int KW = $clog2(N_KEYS) < 1 ? 1 : $clog2(N_KEYS);
    logic [N_KEYS-1:0]      btn;
    logic [CODE_LEN*KW-1:0] code_cfg;
    logic                   led_green;
    logic                   led_red;
    logic                   locked;
    logic [3:0]             entry_cnt;
    modport master (output btn, code_cfg, input led_green, led_red, locked, entry_cnt);
    modport slave (input btn, code_cfg, output led_green, led_red, locked, entry_cnt);
endinterface

// File: rtl/keypad_lock.sv
// keypad_lock: keypad code lock with open/blink indication; KEYPAD_LOCK_LOCKOUT_EN adds failure lockout
module keypad_lock #(
    parameter int N_KEYS         = 4,
    parameter int CODE_LEN       = 4,
    parameter int TIMEOUT        = 10,
    parameter int OPEN_CYCLES    = 3,
    parameter int BLINKS         = 3,
    parameter int MAX_FAIL       = 3,
    parameter int LOCKOUT_CYCLES = 16
) (
    input logic          clk,
    input logic          rs,
    keypad_lock_if.slave bus
);
    localparam int KW = $clog2(N_KEYS) < 1 ? 1 : $clog2(N_KEYS);
    localparam int TW = $clog2(TIMEOUT + 2);
    localparam int M1 = OPEN_CYCLES > 2 * BLINKS ? OPEN_CYCLES : 2 * BLINKS;
    localparam int MD = M1 > LOCKOUT_CYCLES ? M1 : LOCKOUT_CYCLES;
    localparam int DW = $clog2(MD + 1);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT);
    localparam logic [DW-1:0] O_END = DW'(OPEN_CYCLES - 1);
    localparam logic [DW-1:0] E_END = DW'(2 * BLINKS - 1);
    localparam logic [3:0] C_LAST = 4'(CODE_LEN - 1);

    if (N_KEYS < 2 || N_KEYS > 16 || CODE_LEN < 1 || CODE_LEN > 8 || TIMEOUT < 0 ||
        OPEN_CYCLES < 1 || BLINKS < 1 || MAX_FAIL < 1 || LOCKOUT_CYCLES < 1) begin : g_bad_param
        $error("keypad_lock: parameter out of range");
    end

`ifdef KEYPAD_LOCK_LOCKOUT_EN
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam logic [FW-1:0] F_MAX = FW'(MAX_FAIL);
    localparam logic [DW-1:0] L_END = DW'(LOCKOUT_CYCLES - 1);
    typedef enum logic [2:0] {IDLE, ENTRY, CHECK, OPEN, ERROR, LOCKOUT} state_t;
    logic [FW-1:0] fails;
`else
    typedef enum logic [2:0] {IDLE, ENTRY, CHECK, OPEN, ERROR} state_t;
`endif

    state_t                 state, nxt;
    logic [N_KEYS-1:0]      btn_q, press;
    logic                   armed, hit, multi, take, dur_end;
    logic [KW-1:0]          val;
    logic [CODE_LEN*KW-1:0] dig;
    logic                   bad;
    logic [3:0]             cnt;
    logic [TW-1:0]          timer;
    logic [DW-1:0]          dur;

    assign press = armed ? bus.btn & ~btn_q : '0;
    assign hit   = |press;
    assign multi = |(press & (press - 1'b1));
    assign take  = hit && (state == IDLE || state == ENTRY);
`ifdef KEYPAD_LOCK_LOCKOUT_EN
    assign dur_end = dur == (state == OPEN ? O_END : state == ERROR ? E_END : L_END);
`else
    assign dur_end = dur == (state == OPEN ? O_END : E_END);
`endif

    // encode the pressed key into a digit value
    always_comb begin
        val = '0;
        for (int k = 0; k < N_KEYS; k++) if (press[k]) val = KW'(k);
    end

    // state register
    always_ff @(posedge clk or posedge rs) begin
        if (rs) state <= IDLE;
        else state <= nxt;
    end

    // next-state: collect digits, judge once, then show the verdict for a fixed time
    always_comb begin
        nxt = state;
        case (state)
            IDLE, ENTRY: nxt = hit ? (cnt == C_LAST ? CHECK : ENTRY) :
                               (state == ENTRY && timer == T_MAX) ? ERROR : state;
            CHECK:       nxt = (dig == bus.code_cfg && !bad) ? OPEN : ERROR;
            OPEN:        nxt = dur_end ? IDLE : OPEN;
`ifdef KEYPAD_LOCK_LOCKOUT_EN
            ERROR:       nxt = dur_end ? (fails == F_MAX ? LOCKOUT : IDLE) : ERROR;
            LOCKOUT:     nxt = dur_end ? IDLE : LOCKOUT;
`else
            ERROR:       nxt = dur_end ? IDLE : ERROR;
`endif
            default:     nxt = IDLE;
        endcase
    end

    // button history, digit store, inter-digit timer and phase duration counter
    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            btn_q <= '0;
            armed <= 1'b0;
            dig   <= '0;
            bad   <= 1'b0;
            cnt   <= '0;
            timer <= '0;
            dur   <= '0;
        end else begin
            btn_q <= bus.btn;
            armed <= 1'b1;
            timer <= (hit || state != ENTRY) ? '0 : timer == T_MAX ? timer : timer + 1'b1;
            dur   <= nxt != state ? '0 : &dur ? dur : dur + 1'b1;
            cnt   <= take ? cnt + 1'b1 : (nxt == ENTRY || nxt == CHECK) ? cnt : '0;
            if (take) begin
                dig[cnt*KW +: KW] <= val;
                bad <= (state == ENTRY && bad) || multi;
            end
        end
    end

`ifdef KEYPAD_LOCK_LOCKOUT_EN
    // consecutive failure count, cleared by a successful open or a completed lockout
    always_ff @(posedge clk or posedge rs) begin
        if (rs) fails <= '0;
        else if (nxt == OPEN || (state == LOCKOUT && nxt == IDLE)) fails <= '0;
        else if (nxt == ERROR && state != ERROR) fails <= fails == F_MAX ? fails : fails + 1'b1;
    end
`endif

    // indicators decode purely from registered state and counters
    always_comb begin
        bus.led_green = state == OPEN;
        bus.entry_cnt = cnt;
`ifdef KEYPAD_LOCK_LOCKOUT_EN
        bus.led_red   = (state == ERROR && !dur[0]) || state == LOCKOUT;
        bus.locked    = state == LOCKOUT;
`else
        bus.led_red   = state == ERROR && !dur[0];
        bus.locked    = 1'b0;
`endif
    end
endmodule

// File: tb/tb_keypad_lock.sv
// tb_keypad_lock: randomized check of keypad_lock against a transaction-level reference
module tb_keypad_lock;
    localparam int N_KEYS = 4, CODE_LEN = 4, TIMEOUT = 10, OPEN_CYCLES = 3;
    localparam int BLINKS = 3, MAX_FAIL = 3, LOCKOUT_CYCLES = 16, KW = 2;

    typedef struct packed {logic g; logic r; logic l; logic [3:0] c;} out_t;

    logic clk = 1'b0;
    logic rs = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    out_t plan[$];
    out_t cur = '0;
    int got[$];
    int idle = 0;
    int fails = 0;
    bit busy = 0;
    bit armed = 0;
    logic [N_KEYS-1:0] prev = '0;
    int code[CODE_LEN];

    keypad_lock_if #(.N_KEYS(N_KEYS), .CODE_LEN(CODE_LEN)) bus ();

    keypad_lock #(
        .N_KEYS(N_KEYS), .CODE_LEN(CODE_LEN), .TIMEOUT(TIMEOUT), .OPEN_CYCLES(OPEN_CYCLES),
        .BLINKS(BLINKS), .MAX_FAIL(MAX_FAIL), .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) dut (
        .clk(clk),
        .rs(rs),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, want %0h", tag, $time, act, exp);
        end
    endtask

    function automatic out_t mk(input bit g, input bit r, input bit l, input int c);
        mk = '{g: g, r: r, l: l, c: 4'(c)};
    endfunction

    task automatic m_reset();
        plan.delete();
        got.delete();
        cur = '0;
        idle = 0;
        fails = 0;
        busy = 0;
        armed = 0;
        prev = '0;
    endtask

    // failed attempt: blink pattern, plus a lockout window when enough failures pile up
    task automatic m_error();
        for (int i = 0; i < 2 * BLINKS; i++) plan.push_back(mk(0, i % 2 == 0, 0, 0));
`ifdef KEYPAD_LOCK_LOCKOUT_EN
        if (fails < MAX_FAIL) fails++;
        if (fails == MAX_FAIL) begin
            for (int i = 0; i < LOCKOUT_CYCLES; i++) plan.push_back(mk(0, 1, 1, 0));
            fails = 0;
        end
`endif
    endtask

    task automatic m_go();
        got.delete();
        busy = 1;
        cur = plan.pop_front();
    endtask

    // one clock of the reference: digits go in a queue, verdicts become a scripted output plan
    task automatic m_step();
        logic [N_KEYS-1:0] p;
        bit ok;
        p = armed ? bus.btn & ~prev : '0;
        prev = bus.btn;
        armed = 1;
        if (busy) begin
            busy = plan.size() > 0;
            if (busy) cur = plan.pop_front();
            else cur = '0;
        end else if (p != '0) begin
            got.push_back($countones(p) == 1 ? $clog2(p) : -1);
            idle = 0;
            if (got.size() < CODE_LEN) cur = mk(0, 0, 0, got.size());
            else begin
                ok = 1;
                for (int i = 0; i < CODE_LEN; i++) if (got[i] != code[i]) ok = 0;
                plan.push_back(mk(0, 0, 0, CODE_LEN));
                if (ok) begin
                    for (int i = 0; i < OPEN_CYCLES; i++) plan.push_back(mk(1, 0, 0, 0));
                    fails = 0;
                end else m_error();
                m_go();
            end
        end else if (got.size() > 0) begin
            if (idle == TIMEOUT) begin
                m_error();
                m_go();
            end else idle++;
        end
    endtask

    always @(posedge clk or posedge rs) begin
        if (rs) m_reset();
        else m_step();
    end

    always @(negedge clk) check("out", {bus.led_green, bus.led_red, bus.locked, bus.entry_cnt}, cur);

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic key(input logic [N_KEYS-1:0] m, input int hold, input int gap);
        @(negedge clk);
        bus.btn = m;
        tick(hold);
        bus.btn = '0;
        tick(gap);
    endtask

    task automatic enter(input int a, input int b, input int c, input int d, input int gap);
        key(N_KEYS'(1 << a), 1, gap);
        key(N_KEYS'(1 << b), 1, gap);
        key(N_KEYS'(1 << c), 1, gap);
        key(N_KEYS'(1 << d), 1, gap);
    endtask

    task automatic set_code(input int a, input int b, input int c, input int d);
        code = '{a, b, c, d};
        for (int i = 0; i < CODE_LEN; i++) bus.code_cfg[i*KW +: KW] = KW'(code[i]);
    endtask

    task automatic wait_green(input string tag);
        for (int i = 0; i < 20 && !bus.led_green; i++) @(negedge clk);
        check(tag, bus.led_green, 1);
    endtask

    initial begin
        int r, d, hold, gap;
        logic [N_KEYS-1:0] m;
        bus.btn = 4'b0100;
        set_code(1, 3, 2, 0);
        tick(3);
        #2 rs = 1'b0;
        tick(3);
        bus.btn = '0;
        tick(2);
        enter(1, 3, 2, 0, 2);
        tick(12);
        enter(1, 3, 3, 0, 1);
        tick(12);
        key(4'b0010, 1, 0);
        tick(20);
        key(4'b0010, 4, 1);
        key(4'b0101, 1, 1);
        key(4'b0100, 1, 1);
        key(4'b0001, 1, 1);
        tick(12);
        repeat (3) begin
            enter(0, 0, 0, 0, 0);
            tick(8);
        end
        repeat (4) key(N_KEYS'($urandom_range(1, 15)), 1, 1);
        tick(10);
        enter(1, 3, 2, 0, 1);
        wait_green("lock_reopen");
        tick(10);
        enter(1, 3, 2, 0, 1);
        wait_green("open_seen");
        @(negedge clk);
        #2 rs = 1'b1;
        #1 check("async_rst", {bus.led_green, bus.led_red, bus.locked, bus.entry_cnt}, 0);
        tick(2);
        #2 rs = 1'b0;
        enter(1, 3, 2, 0, 1);
        wait_green("post_rst_open");
        tick(6);
        repeat (60) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                #2 rs = 1'b1;
                tick(1);
                #2 rs = 1'b0;
            end else begin
                if (r == 1 && !busy && got.size() == 0)
                    set_code($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
                for (int i = 0; i < CODE_LEN; i++) begin
                    d = r < 6 ? code[i] : $urandom_range(0, 3);
                    m = N_KEYS'(1 << d);
                    if ($urandom_range(0, 15) == 0) m = m | N_KEYS'(1 << $urandom_range(0, 3));
                    hold = $urandom_range(1, 3);
                    gap = $urandom_range(0, 4) == 0 ? $urandom_range(8, 12) : $urandom_range(0, 2);
                    key(m, hold, gap);
                end
            end
            tick($urandom_range(0, 30));
        end
        tick(30);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
